// File: rtl/tpu_pkg.sv
// Shared TPU types: instruction word, buffer/accumulator address types,
// the MATMUL opcode prefix and the matmul sequencer state encoding.
package tpu_pkg;

    typedef logic [23:0] buffer_addr_type;
    typedef logic [15:0] accumulator_addr_type;

    typedef struct packed {
        logic [7:0]           opcode;
        logic [31:0]          length;
        accumulator_addr_type acc_addr;
        buffer_addr_type      buffer_addr;
    } instr_type;

    localparam instr_type INIT_INSTR = '0;

    localparam logic [3:0] MATMUL_OPCODE_PREFIX = 4'b0010;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_ISSUE,
        MM_DRAIN
    } mm_state_t;

endpackage

// File: rtl/flow_delay_line.sv
// Enable-gated shift register with synchronous reset.
// Ports: clk, rst, en (shift advance), d (input word), q (word after DEPTH shifts).
module flow_delay_line #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 1,
    parameter bit WITH_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];
    logic             shift;

    assign shift = WITH_ENABLE ? en : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (shift) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/matmul_flow_controller.sv
// MATRIX_MULTIPLY sequencer: streams unified-buffer rows into the MMU and
// writes results to the accumulators RESULT_LATENCY enabled cycles later.
// Ports: clk, rst, enable (global stall), instr/instr_enable (issue),
//   buf_read_* (buffer port), mmu_* / activate_weight (MMU control),
//   acc_write_* / accumulate (accumulator port), busy, resource_busy.
module matmul_flow_controller
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH   = 14,
    parameter int RESULT_LATENCY = 2 * MATRIX_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  instr_type            instr,
    input  logic                 instr_enable,
    output buffer_addr_type      buf_read_addr,
    output logic                 buf_read_en,
    output logic                 mmu_sds_en,
    output logic                 mmu_signed,
    output logic                 activate_weight,
    output accumulator_addr_type acc_write_addr,
    output logic                 accumulate,
    output logic                 acc_write_en,
    output logic                 busy,
    output logic                 resource_busy
);

    mm_state_t            state;
    logic [31:0]          len_q;
    logic [31:0]          rd_cnt;
    logic [31:0]          wr_cnt;
    buffer_addr_type      buf_base;
    accumulator_addr_type acc_base;

    logic                 accept;
    logic                 last_rd;
    logic                 last_wr;
    logic [16:0]          res_d;
    logic [16:0]          res_q;
    logic [0:0]           sds_d;
    logic [0:0]           sds_q;
    logic                 unused_ok;

    // opcode[3:2] carry no meaning for MATMUL
    assign unused_ok = ^instr.opcode[3:2];

    // A zero-length MATMUL is dropped here so it never touches any output.
    assign accept = enable && instr_enable && (state == MM_IDLE)
                 && (instr.opcode[7:4] == MATMUL_OPCODE_PREFIX)
                 && (instr.length != 32'd0);

    assign last_rd = (rd_cnt == len_q - 32'd1);
    assign last_wr = (wr_cnt == len_q - 32'd1);

    // Strobes are gated by enable in the same cycle; state only moves on enable.
    assign buf_read_en     = enable && (state == MM_ISSUE);
    assign buf_read_addr   = buf_base + rd_cnt[23:0];
    assign activate_weight = buf_read_en && (rd_cnt == 32'd0);
    assign resource_busy   = (state == MM_ISSUE);
    assign busy            = (state != MM_IDLE);

    assign res_d = {buf_read_en, acc_base + rd_cnt[15:0]};
    assign sds_d = buf_read_en;

    assign acc_write_en   = enable && res_q[16];
    assign acc_write_addr = res_q[15:0];
    assign mmu_sds_en     = enable && sds_q[0];

    flow_delay_line #(
        .WIDTH       (17),
        .DEPTH       (RESULT_LATENCY),
        .WITH_ENABLE (1'b1)
    ) u_result_dl (
        .clk (clk),
        .rst (rst),
        .en  (enable),
        .d   (res_d),
        .q   (res_q)
    );

    flow_delay_line #(
        .WIDTH       (1),
        .DEPTH       (1),
        .WITH_ENABLE (1'b1)
    ) u_sds_dl (
        .clk (clk),
        .rst (rst),
        .en  (enable),
        .d   (sds_d),
        .q   (sds_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MM_IDLE;
            len_q      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            buf_base   <= '0;
            acc_base   <= '0;
            accumulate <= 1'b0;
            mmu_signed <= 1'b0;
        end else if (enable) begin
            unique case (state)
                MM_IDLE: begin
                    if (accept) begin
                        state      <= MM_ISSUE;
                        len_q      <= instr.length;
                        rd_cnt     <= '0;
                        wr_cnt     <= '0;
                        buf_base   <= instr.buffer_addr;
                        acc_base   <= instr.acc_addr;
                        accumulate <= instr.opcode[0];
                        mmu_signed <= instr.opcode[1];
                    end
                end
                MM_ISSUE: begin
                    rd_cnt <= rd_cnt + 32'd1;
                    if (last_rd) begin
                        state <= MM_DRAIN;
                    end
                end
                MM_DRAIN: begin
                end
                default: begin
                    state <= MM_IDLE;
                end
            endcase
            // Writes can begin while still issuing when length exceeds the latency.
            if (acc_write_en) begin
                wr_cnt <= wr_cnt + 32'd1;
                if (last_wr) begin
                    state <= MM_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_flow_controller.sv
// Self-checking bench for matmul_flow_controller: queue-based reference
// model checked every cycle, plus directed literal expectations.
module tb_matmul_flow_controller;
    import tpu_pkg::*;

    localparam int LAT = 29;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    instr_type            instr;
    logic                 instr_enable;
    buffer_addr_type      buf_read_addr;
    logic                 buf_read_en;
    logic                 mmu_sds_en;
    logic                 mmu_signed;
    logic                 activate_weight;
    accumulator_addr_type acc_write_addr;
    logic                 accumulate;
    logic                 acc_write_en;
    logic                 busy;
    logic                 resource_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_flow_controller dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .instr           (instr),
        .instr_enable    (instr_enable),
        .buf_read_addr   (buf_read_addr),
        .buf_read_en     (buf_read_en),
        .mmu_sds_en      (mmu_sds_en),
        .mmu_signed      (mmu_signed),
        .activate_weight (activate_weight),
        .acc_write_addr  (acc_write_addr),
        .accumulate      (accumulate),
        .acc_write_en    (acc_write_en),
        .busy            (busy),
        .resource_busy   (resource_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          cyc;
        int unsigned addr;
    } ev_t;

    ev_t rd_log[$];
    ev_t wr_log[$];
    int  act_log[$];
    int  bsy_cnt;
    int  cyc = 0;

    typedef struct {
        logic [15:0] addr;
        int          rem;
    } pw_t;

    pw_t         pq[$];
    logic        m_on = 1'b0;
    logic        m_busy, m_iss, m_acc, m_sgn, m_prev_rd;
    int unsigned m_len, m_rd_idx, m_wr_left;
    logic [23:0] m_bbase;
    logic [15:0] m_abase;

    logic        e_rd, e_act, e_sds, e_wr, was_idle;
    logic [23:0] e_raddr;
    logic [15:0] e_waddr;

    // Reference model: evaluate expectations for this cycle, compare,
    // then advance the model as the coming rising edge would.
    always @(negedge clk) begin
        cyc++;
        e_rd    = m_iss && enable;
        e_raddr = m_bbase + 24'(m_rd_idx);
        e_act   = e_rd && (m_rd_idx == 0);
        e_sds   = enable && m_prev_rd;
        e_wr    = enable && (pq.size() > 0) && (pq[0].rem == 1);
        e_waddr = (pq.size() > 0) ? pq[0].addr : 16'h0;
        if (m_on) begin
            chk("buf_read_en", 32'(buf_read_en), 32'(e_rd));
            chk("activate_weight", 32'(activate_weight), 32'(e_act));
            chk("mmu_sds_en", 32'(mmu_sds_en), 32'(e_sds));
            chk("acc_write_en", 32'(acc_write_en), 32'(e_wr));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("resource_busy", 32'(resource_busy), 32'(m_iss));
            chk("accumulate", 32'(accumulate), 32'(m_acc));
            chk("mmu_signed", 32'(mmu_signed), 32'(m_sgn));
            if (e_rd) chk("buf_read_addr", 32'(buf_read_addr), 32'(e_raddr));
            if (e_wr) chk("acc_write_addr", 32'(acc_write_addr), 32'(e_waddr));
            if (buf_read_en) rd_log.push_back('{cyc, 32'(buf_read_addr)});
            if (acc_write_en) wr_log.push_back('{cyc, 32'(acc_write_addr)});
            if (activate_weight) act_log.push_back(cyc);
            if (busy) bsy_cnt++;
        end
        if (rst) begin
            m_on = 1'b1;
            m_busy = 0; m_iss = 0; m_acc = 0; m_sgn = 0; m_prev_rd = 0;
            m_len = 0; m_rd_idx = 0; m_wr_left = 0;
            m_bbase = 0; m_abase = 0;
            pq.delete();
        end else if (enable) begin
            was_idle = !m_busy;
            foreach (pq[i]) pq[i].rem--;
            while (pq.size() > 0 && pq[0].rem == 0) begin
                void'(pq.pop_front());
                m_wr_left--;
                if (m_wr_left == 0) m_busy = 0;
            end
            m_prev_rd = e_rd;
            if (e_rd) begin
                pq.push_back('{m_abase + 16'(m_rd_idx), LAT});
                m_rd_idx++;
                if (m_rd_idx == m_len) m_iss = 0;
            end
            if (was_idle && instr_enable && instr.opcode[7:4] == 4'h2
                && instr.length != 0) begin
                m_busy = 1; m_iss = 1;
                m_len = instr.length; m_wr_left = instr.length; m_rd_idx = 0;
                m_bbase = instr.buffer_addr; m_abase = instr.acc_addr;
                m_acc = instr.opcode[0]; m_sgn = instr.opcode[1];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        act_log.delete();
        bsy_cnt = 0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] len,
                         input logic [23:0] ba, input logic [15:0] aa);
        instr = '{opcode: op, length: len, acc_addr: aa, buffer_addr: ba};
        instr_enable = 1'b1;
        tick();
        instr_enable = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        int unsigned exp_rd3[3];
        int unsigned exp_wr3[3];
        int          gaps4[5];
        int          n;

        rst = 1'b1; enable = 1'b1; instr_enable = 1'b0; instr = INIT_INSTR;
        tick(); tick();
        rst = 1'b0;
        tick();

        // basic
        clear_logs();
        issue(8'h21, 32'd5, 24'h000084, 16'h0946);
        wait_idle(200);
        chk("t2_nrd", rd_log.size(), 5);
        chk("t2_nwr", wr_log.size(), 5);
        chk("t2_nact", act_log.size(), 1);
        if (act_log.size() > 0 && rd_log.size() > 0)
            chk("t2_act_first", act_log[0], rd_log[0].cyc);
        for (int i = 0; i < 5 && i < rd_log.size() && i < wr_log.size(); i++) begin
            chk("t2_rd_addr", rd_log[i].addr, 32'h84 + i);
            chk("t2_wr_addr", wr_log[i].addr, 32'h946 + i);
            chk("t2_gap", wr_log[i].cyc - rd_log[i].cyc, 29);
            if (i > 0) chk("t2_rd_consec", rd_log[i].cyc - rd_log[i-1].cyc, 1);
        end
        chk("t2_busy_cycles", bsy_cnt, 34);
        tick();

        // wrap
        clear_logs();
        exp_rd3 = '{32'hFFFFFE, 32'hFFFFFF, 32'h000000};
        exp_wr3 = '{32'hFFFF, 32'h0000, 32'h0001};
        issue(8'h20, 32'd3, 24'hFFFFFE, 16'hFFFF);
        wait_idle(200);
        chk("t3_nrd", rd_log.size(), 3);
        chk("t3_nwr", wr_log.size(), 3);
        for (int i = 0; i < 3 && i < rd_log.size() && i < wr_log.size(); i++) begin
            chk("t3_rd_addr", rd_log[i].addr, exp_rd3[i]);
            chk("t3_wr_addr", wr_log[i].addr, exp_wr3[i]);
        end

        // stall after the second read
        clear_logs();
        gaps4 = '{33, 33, 29, 29, 29};
        issue(8'h21, 32'd5, 24'h000100, 16'h0200);
        tick();
        tick();
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        wait_idle(200);
        chk("t4_nrd", rd_log.size(), 5);
        chk("t4_nwr", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < rd_log.size() && i < wr_log.size(); i++)
            chk("t4_gap", wr_log[i].cyc - rd_log[i].cyc, gaps4[i]);
        chk("t4_busy_cycles", bsy_cnt, 38);

        // rejects
        clear_logs();
        issue(8'h21, 32'd0, 24'h000010, 16'h0010);
        repeat (5) tick();
        chk("t5_len0_busy", bsy_cnt, 0);
        issue(8'h99, 32'd5, 24'h000010, 16'h0010);
        repeat (5) tick();
        chk("t5_badop_busy", bsy_cnt, 0);
        chk("t5_badop_rd", rd_log.size(), 0);
        issue(8'h20, 32'd4, 24'h000010, 16'h0020);
        tick();
        issue(8'h21, 32'd7, 24'h000500, 16'h0600);
        wait_idle(200);
        chk("t5_busy_rd", rd_log.size(), 4);
        chk("t5_busy_wr", wr_log.size(), 4);
        if (rd_log.size() > 0) chk("t5_rd0", rd_log[0].addr, 32'h10);

        // back-to-back
        clear_logs();
        issue(8'h23, 32'd3, 24'h000200, 16'h0300);
        wait_idle(200);
        chk("t6_sgn_held", 32'(mmu_signed), 1);
        issue(8'h20, 32'd2, 24'h000400, 16'h0500);
        chk("t6_accepted", 32'(busy), 1);
        chk("t6_sgn_new", 32'(mmu_signed), 0);
        wait_idle(200);
        chk("t6_nrd", rd_log.size(), 5);

        // reset mid-issue
        clear_logs();
        issue(8'h22, 32'd10, 24'h000700, 16'h0800);
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("t1_busy", 32'(busy), 0);
        chk("t1_rd_en", 32'(buf_read_en), 0);
        chk("t1_sgn", 32'(mmu_signed), 0);
        chk("t1_rd_addr", 32'(buf_read_addr), 0);
        chk("t1_rbusy", 32'(resource_busy), 0);
        wr_log.delete();
        repeat (40) tick();
        chk("t1_no_stray_wr", wr_log.size(), 0);

        // randomized traffic
        n = 0;
        repeat (3000) begin
            logic [2:0] r;
            rst = ($urandom_range(0, 399) == 0);
            enable = ($urandom_range(0, 9) != 0);
            instr_enable = ($urandom_range(0, 3) == 0);
            r = 3'($urandom_range(0, 4));
            instr.opcode = (r < 4) ? (8'h20 | 8'(r)) : 8'($urandom);
            instr.length = ($urandom_range(0, 9) == 0) ? 32'd0
                         : 32'($urandom_range(1, 40));
            instr.buffer_addr = ($urandom_range(0, 3) == 0)
                              ? 24'hFFFFF0 | 24'($urandom_range(0, 15))
                              : 24'($urandom);
            instr.acc_addr = 16'($urandom);
            tick();
            n++;
        end
        rst = 1'b0; enable = 1'b1; instr_enable = 1'b0;
        wait_idle(300);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
